// File: rtl/data_sram_bridge_if.sv
// Data-bus side of data_sram_bridge: request/accept handshake plus response channel.
// master = bridge (issues requests), slave = bus / cache port.
interface data_sram_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_strb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_strb, bus_addr, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_strb, bus_addr, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Responder for the memory-stage SRAM-style data port: turns each request into a bus
// transaction and stalls the pipeline until it completes. DATA_WBUF_EN adds a posted write buffer.
module data_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_en,
  input  logic [3:0]         mem_wen,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_stall,
  output logic               data_bus_error,
  data_sram_bridge_if.master dbus
);

`ifdef DATA_WBUF_EN
  localparam bit WbufEn = 1'b1;
`else
  localparam bit WbufEn = 1'b0;
`endif

  // Counter only ever reaches TIMEOUT_CYCLES-1 before the forced completion.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            posted_q, posted_d;
  logic            err_q, err_d;
  logic [3:0]      strb_q, strb_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    posted_d  = posted_q;
    err_d     = 1'b0;
    strb_d    = strb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_stall = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_stall = mem_en;
        if (mem_en) begin
          state_d = StAddr;
          req_d   = 1'b1;
          we_d    = |mem_wen;
          strb_d  = (|mem_wen) ? mem_wen : 4'b1111;
          addr_d  = {mem_addr[31:2], 2'b00};
          wdata_d = mem_wdata;
          // Posted write: the pipeline moves on while the buffer drains.
          if (WbufEn && (|mem_wen)) begin
            posted_d  = 1'b1;
            mem_stall = 1'b0;
          end
        end
      end
      StAddr: begin
        mem_stall = posted_q ? mem_en : 1'b1;
        if (dbus.bus_ready) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        mem_stall = posted_q ? mem_en : 1'b1;
        cnt_d     = cnt_q + CntW'(1);
        if (dbus.bus_rvalid || timeout_hit) begin
          if (dbus.bus_rvalid && !dbus.bus_err) begin
            if (!we_q) rdata_d = dbus.bus_rdata;
          end else begin
            err_d = 1'b1;
            if (!we_q) rdata_d = TIMEOUT_DATA;
          end
          state_d  = posted_q ? StIdle : StDone;
          posted_d = 1'b0;
        end
      end
      StDone: begin
        // The request still visible here is the one just completed.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      posted_q <= 1'b0;
      err_q    <= 1'b0;
      strb_q   <= 4'b0000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      posted_q <= posted_d;
      err_q    <= err_d;
      strb_q   <= strb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dbus.bus_req    = req_q;
  assign dbus.bus_we     = we_q;
  assign dbus.bus_strb   = strb_q;
  assign dbus.bus_addr   = addr_q;
  assign dbus.bus_wdata  = wdata_q;
  assign mem_rdata       = rdata_q;
  assign data_bus_error  = err_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: vector table plus hand sequences for reset
// abandonment and write-then-read; bus responder with per-vector ready/rvalid delays.
module tb_data_sram_bridge;
  localparam int unsigned NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_bus_error;

  data_sram_bridge_if dbus ();

  data_sram_bridge #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_en        (mem_en),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .data_bus_error(data_bus_error),
    .dbus          (dbus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- bus responder ----------------
  int unsigned cfg_ready_dly  = 0;
  int unsigned cfg_rvalid_dly = 0;
  bit          cfg_err        = 1'b0;
  bit          m_ready        = 1'b0;
  bit          m_rvalid       = 1'b0;
  bit          m_err          = 1'b0;
  logic [31:0] m_rdata        = 32'h0;
  bit          stray_rvalid   = 1'b0;
  bit          phase          = 1'b0;
  int unsigned wait_cnt       = 0;
  logic        pend_we;
  logic [3:0]  pend_strb;
  logic [31:0] pend_addr;
  logic [31:0] pend_wdata;
  logic [31:0] mem_model [logic [29:0]];

  assign dbus.bus_ready  = m_ready;
  assign dbus.bus_rvalid = m_rvalid | stray_rvalid;
  assign dbus.bus_err    = m_err;
  assign dbus.bus_rdata  = stray_rvalid ? 32'h5555_AAAA : m_rdata;

  always @(negedge clk) begin
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    if (!rst) begin
      phase    = 1'b0;
      wait_cnt = 0;
    end else if (dbus.bus_req) begin
      if (phase) begin
        phase    = 1'b0;
        wait_cnt = 0;
      end
      if (wait_cnt >= cfg_ready_dly) begin
        m_ready    = 1'b1;
        phase      = 1'b1;
        wait_cnt   = 0;
        pend_we    = dbus.bus_we;
        pend_strb  = dbus.bus_strb;
        pend_addr  = dbus.bus_addr;
        pend_wdata = dbus.bus_wdata;
      end else begin
        wait_cnt++;
      end
    end else if (phase) begin
      if (wait_cnt >= cfg_rvalid_dly) begin
        m_rvalid = 1'b1;
        m_err    = cfg_err;
        phase    = 1'b0;
        wait_cnt = 0;
        if (!pend_we) begin
          m_rdata = mem_model.exists(pend_addr[31:2]) ? mem_model[pend_addr[31:2]] : 32'h0;
        end else if (!cfg_err) begin
          logic [31:0] w;
          w = mem_model.exists(pend_addr[31:2]) ? mem_model[pend_addr[31:2]] : 32'h0;
          for (int b = 0; b < 4; b++) if (pend_strb[b]) w[8*b +: 8] = pend_wdata[8*b +: 8];
          mem_model[pend_addr[31:2]] = w;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned ready_dly;
    int unsigned rvalid_dly;
    bit          err;
    bit          preload;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int unsigned exp_stalls;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  task automatic run_req(input vec_t v, input string tag);
    int          stalls    = 0;
    int          cyc       = 0;
    bit          fields_ok = 1'b1;
    bit          seen_req  = 1'b0;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    exp_t        e;
    e_addr = {v.addr[31:2], 2'b00};
    e_strb = (v.wen != 4'b0) ? v.wen : 4'b1111;
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    cfg_ready_dly  = v.ready_dly;
    cfg_rvalid_dly = v.rvalid_dly;
    cfg_err        = v.err;
    if (v.wen == 4'b0 && v.preload) mem_model[e_addr[31:2]] = v.rdata;
    @(negedge clk);
    mem_en    = 1'b1;
    mem_wen   = v.wen;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    #1;
    while (mem_stall && cyc < 40) begin
      stalls++;
      if (dbus.bus_req) begin
        seen_req = 1'b1;
        if (dbus.bus_addr !== e_addr || dbus.bus_strb !== e_strb ||
            dbus.bus_we !== (v.wen != 4'b0) ||
            (v.wen != 4'b0 && dbus.bus_wdata !== v.wdata)) fields_ok = 1'b0;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_completes"}, mem_stall, 1'b0);
    e = exp_q.pop_front();
    check({tag, "_rdata"}, mem_rdata, e.rdata);
    check({tag, "_err"}, data_bus_error, e.err);
`ifndef DATA_WBUF_EN
    check({tag, "_stalls"}, stalls, v.exp_stalls);
`endif
    check({tag, "_bus_fields"}, fields_ok & seen_req, 1'b1);
    @(negedge clk);
    mem_en  = 1'b0;
    mem_wen = 4'b0;
    #1;
    check({tag, "_err_pulse_end"}, data_bus_error, 1'b0);
    check({tag, "_idle_nostall"}, mem_stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int cyc;
    vecs[0] = '{4'h0, 32'h8000_0104, 32'h0, 0, 0, 1'b0, 1'b1, 32'h1234_5678,
                32'h1234_5678, 1'b0, 3};
    vecs[1] = '{4'b0100, 32'h0000_0012, 32'hABAB_ABAB, 5, 0, 1'b0, 1'b0, 32'h0,
                32'h1234_5678, 1'b0, 8};
    vecs[2] = '{4'h0, 32'h0000_0040, 32'h0, 0, 1, 1'b1, 1'b1, 32'h7777_7777,
                32'hDEAD_BEEF, 1'b1, 4};
    vecs[3] = '{4'h0, 32'h0000_0044, 32'h0, 0, NEVER, 1'b0, 1'b1, 32'h6666_6666,
                32'hDEAD_BEEF, 1'b1, 6};
    vecs[4] = '{4'h0, 32'h0000_0200, 32'h0, 2, 2, 1'b0, 1'b1, 32'hCAFE_F00D,
                32'hCAFE_F00D, 1'b0, 7};
    vecs[5] = '{4'hF, 32'h0000_0204, 32'h0BAD_F00D, 0, 2, 1'b0, 1'b0, 32'h0,
                32'hCAFE_F00D, 1'b0, 5};
    vecs[6] = '{4'b0011, 32'h0000_0302, 32'h1357_9BDF, 1, 0, 1'b1, 1'b0, 32'h0,
                32'hCAFE_F00D, 1'b1, 4};
    vecs[7] = '{4'h0, 32'h1000_0008, 32'h0, 0, 0, 1'b0, 1'b1, 32'h0F0F_5A5A,
                32'h0F0F_5A5A, 1'b0, 3};

    rst       = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 4'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    #2;
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_bus_req", dbus.bus_req, 1'b0);
    check("reset_bus_strb", dbus.bus_strb, 4'b0);
    check("reset_err", data_bus_error, 1'b0);
    check("reset_stall", mem_stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
`ifdef DATA_WBUF_EN
      if (vecs[i].wen != 4'b0) continue;
`endif
      run_req(vecs[i], $sformatf("row%0d", i));
    end

    // Abandon a read in RESP with reset, then offer a stray response in IDLE.
    cfg_ready_dly  = 0;
    cfg_rvalid_dly = NEVER;
    cfg_err        = 1'b0;
    @(negedge clk);
    mem_en   = 1'b1;
    mem_wen  = 4'b0;
    mem_addr = 32'h0000_0080;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_pre_stall", mem_stall, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_bus_req", dbus.bus_req, 1'b0);
    check("rst_bus_addr", dbus.bus_addr, 32'h0);
    check("rst_bus_strb", dbus.bus_strb, 4'b0);
    mem_en = 1'b0;
    #1;
    check("rst_stall", mem_stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stray_rvalid = 1'b1;
    @(negedge clk);
    stray_rvalid = 1'b0;
    #1;
    check("stray_rdata", mem_rdata, 32'h0);
    check("stray_err", data_bus_error, 1'b0);
    check("stray_bus_req", dbus.bus_req, 1'b0);
    run_req(vecs[0], "post_rst_read");

    // Write then read back-to-back from the same word.
    cfg_ready_dly  = 0;
    cfg_rvalid_dly = 0;
    cfg_err        = 1'b0;
`ifdef DATA_WBUF_EN
    @(negedge clk);
    mem_en    = 1'b1;
    mem_wen   = 4'hF;
    mem_addr  = 32'h0000_0400;
    mem_wdata = 32'h5A5A_1234;
    #1;
    check("wbuf_zero_stall", mem_stall, 1'b0);
    @(negedge clk);
    mem_wen   = 4'b0;
    mem_wdata = 32'h0;
    #1;
    stalls = 0;
    cyc    = 0;
    while (mem_stall && cyc < 40) begin
      stalls++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check("wbuf_read_stalls", stalls, 5);
    check("wbuf_read_data", mem_rdata, 32'h5A5A_1234);
    @(negedge clk);
    mem_en = 1'b0;
`else
    stalls = 0;
    cyc    = 0;
    run_req('{4'hF, 32'h0000_0400, 32'h5A5A_1234, 0, 0, 1'b0, 1'b0, 32'h0,
              32'h1234_5678, 1'b0, 3}, "wr_400");
    run_req('{4'h0, 32'h0000_0400, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0,
              32'h5A5A_1234, 1'b0, 3}, "rd_400");
`endif
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
